// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button conditioning chain.
// The long-press feature is enabled by defining LONGPRESS_EN.
package debounce_pkg;

  typedef enum logic [1:0] {
    REL = 2'd0,
    PRS = 2'd1,
    LNG = 2'd2
  } state_e;

  localparam int DEF_SAMPLE_DIV = 100000;
  localparam int DEF_FILTER_LEN = 4;
  localparam int DEF_LONG_TICKS = 1000;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-clk tick every SAMPLE_DIV cycles.
// Shared by every button/keypad filter that needs a slow sample strobe.
module sample_tick_gen
  import debounce_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int                CNT_W = cnt_width(SAMPLE_DIV);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/debounce_onepulse.sv
// Button conditioner: 2-flop synchroniser, sampled shift-register filter, one-pulse FSM.
// Define LONGPRESS_EN to build the hold counter, LNG state and long_pulse output.
module debounce_onepulse
  import debounce_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int FILTER_LEN = DEF_FILTER_LEN,
  parameter int LONG_TICKS = DEF_LONG_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_in,
  output logic pb_debounced,
  output logic pb_pulse,
  output logic long_pulse
);

  if (SAMPLE_DIV < 2 || FILTER_LEN < 2 || LONG_TICKS < 1) begin : g_param_check
    $error("debounce_onepulse: parameter out of range");
  end

  logic                  tick;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic [FILTER_LEN-1:0] shreg_q, shreg_d;
  logic                  deb_q, deb_d;
  logic                  pulse_q, pulse_d;
  logic                  rise, fall;
  state_e                state_q, state_d;

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Level only flips on a unanimous window; mixed windows hold the previous level.
  always_comb begin
    s0_d    = pb_in;
    s1_d    = s0_q;
    shreg_d = shreg_q;
    deb_d   = deb_q;
    if (tick) begin
      shreg_d = {shreg_q[FILTER_LEN-2:0], s1_q};
      if (&shreg_d) begin
        deb_d = 1'b1;
      end else if (~|shreg_d) begin
        deb_d = 1'b0;
      end
    end
    rise = deb_d & ~deb_q;
    fall = deb_q & ~deb_d;
  end

`ifdef LONGPRESS_EN
  localparam int               HOLD_W    = cnt_width(LONG_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;
`endif

  // A release on the qualifying tick is checked first so it suppresses long_pulse.
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
`ifdef LONGPRESS_EN
    long_d  = 1'b0;
`endif
    case (state_q)
      REL: begin
        if (rise) begin
          state_d = PRS;
          pulse_d = 1'b1;
        end
      end
      PRS: begin
        if (fall) begin
          state_d = REL;
`ifdef LONGPRESS_EN
        end else if (tick && hold_q == HOLD_LAST) begin
          state_d = LNG;
          long_d  = 1'b1;
`endif
        end
      end
      LNG: begin
        if (fall) begin
          state_d = REL;
        end
      end
      default: state_d = REL;
    endcase
`ifdef LONGPRESS_EN
    hold_d = hold_q;
    if (state_q == REL || state_d == REL) begin
      hold_d = '0;
    end else if (tick && hold_q != HOLD_MAX) begin
      hold_d = hold_q + HOLD_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      shreg_q <= '0;
      deb_q   <= 1'b0;
      pulse_q <= 1'b0;
      state_q <= REL;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      shreg_q <= shreg_d;
      deb_q   <= deb_d;
      pulse_q <= pulse_d;
      state_q <= state_d;
    end
  end

`ifdef LONGPRESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

  assign pb_debounced = deb_q;
  assign pb_pulse     = pulse_q;

endmodule

// File: tb/tb_debounce_onepulse.sv
// Directed bench for debounce_onepulse with SAMPLE_DIV=4, FILTER_LEN=4, LONG_TICKS=8.
// Expectations follow the LONGPRESS_EN define so the same bench covers both builds.
module tb_debounce_onepulse;

`ifdef LONGPRESS_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic pb_in;
  logic pb_debounced;
  logic pb_pulse;
  logic long_pulse;

  int checks = 0;
  int passed = 0;
  int pulse_total = 0;
  int long_total = 0;
  int viol = 0;
  int presses = 0;
  logic prev_deb = 1'b0;
  logic prev_long = 1'b0;
  logic count_en = 1'b0;

  typedef struct {
    logic  pb;
    int    cycles;
    int    exp_pulses;
    int    exp_longs;
    int    exp_deb;
    string name;
  } vec_t;

  vec_t vecs[$];

  debounce_onepulse #(
    .SAMPLE_DIV (4),
    .FILTER_LEN (4),
    .LONG_TICKS (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pb_in        (pb_in),
    .pb_debounced (pb_debounced),
    .pb_pulse     (pb_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 clk = ~clk;

  // Downstream toggle FSM model plus per-cycle protocol monitor.
  always @(posedge clk) begin
    #1;
    if (pb_pulse !== (pb_debounced && !prev_deb)) viol++;
    if (long_pulse && prev_long) viol++;
    if (pb_pulse) begin
      pulse_total++;
      count_en = ~count_en;
    end
    if (long_pulse) long_total++;
    prev_deb  = pb_debounced;
    prev_long = long_pulse;
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic checkRange(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got >= lo && got <= hi) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
  endtask

  task automatic applyStimulus(input logic pb, input int cycles, input int ep,
                               input int el, input int ed, input string name);
    int p0, l0;
    p0 = pulse_total;
    l0 = long_total;
    pb_in = pb;
    repeat (cycles) @(negedge clk);
    checkOutput({name, "_pulses"}, pulse_total - p0, ep);
    checkOutput({name, "_longs"}, long_total - l0, el);
    checkOutput({name, "_deb"}, int'(pb_debounced), ed);
  endtask

  task automatic waitPulse(input int bound, output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (pb_pulse) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pressReleaseAt(input int k, input int exp_long, input string name);
    int lat, p0, l0;
    p0 = pulse_total;
    l0 = long_total;
    pb_in = 1'b1;
    waitPulse(30, lat);
    checkRange({name, "_press_latency"}, lat, 1, 18);
    repeat (k) @(negedge clk);
    pb_in = 1'b0;
    repeat (40) @(negedge clk);
    presses++;
    checkOutput({name, "_pulses"}, pulse_total - p0, 1);
    checkOutput({name, "_longs"}, long_total - l0, exp_long);
    checkOutput({name, "_deb"}, int'(pb_debounced), 0);
  endtask

  initial begin
    int lat, gap, l0;

    vecs.push_back('{1'b0, 40, 0, 0, 0, "idle"});
    vecs.push_back('{1'b1, 200, 1, L, 1, "clean_press"});
    vecs.push_back('{1'b0, 18, 0, 0, 0, "clean_release_18"});
    vecs.push_back('{1'b0, 20, 0, 0, 0, "idle2"});
    for (int i = 0; i < 14; i++) vecs.push_back('{~i[0], 3, 0, 0, 0, "bounce"});
    vecs.push_back('{1'b1, 60, 1, L, 1, "settle"});
    vecs.push_back('{1'b0, 4, 0, 0, 1, "glitch"});
    vecs.push_back('{1'b1, 40, 0, 0, 1, "after_glitch"});
    vecs.push_back('{1'b0, 30, 0, 0, 0, "release2"});

    // Reset held with the button pressed.
    rst_n = 1'b0;
    pb_in = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_deb", int'(pb_debounced), 0);
    checkOutput("rst_pulse", int'(pb_pulse), 0);
    checkOutput("rst_long", int'(long_pulse), 0);
    rst_n = 1'b1;
    waitPulse(30, lat);
    checkRange("rst_release_latency", lat, 1, 18);
    presses++;
    @(negedge clk);
    checkOutput("rst_held_deb", int'(pb_debounced), 1);
    applyStimulus(1'b0, 40, 0, 0, 0, "rst_release");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].pb, vecs[i].cycles, vecs[i].exp_pulses,
                    vecs[i].exp_longs, vecs[i].exp_deb, vecs[i].name);
      presses += vecs[i].exp_pulses;
    end

    // Long press: long_pulse exactly 8 ticks (32 clk) after pb_pulse, never repeated.
    l0 = long_total;
    pb_in = 1'b1;
    waitPulse(30, lat);
    checkRange("long_press_latency", lat, 1, 18);
    presses++;
    gap = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (long_pulse) begin
        gap = i;
        break;
      end
    end
    checkOutput("long_gap", gap, (L != 0) ? 32 : -1);
    applyStimulus(1'b1, 60, 0, 0, 1, "long_hold_more");
    checkOutput("long_total", long_total - l0, L);
    applyStimulus(1'b0, 30, 0, 0, 0, "long_release");

    // Release timed so the fall lands on the tick that would qualify long.
    pressReleaseAt(16, 0, "fall_on_long_tick");
    applyStimulus(1'b0, 10, 0, 0, 0, "idle3");
    pressReleaseAt(20, L, "fall_one_tick_late");
    applyStimulus(1'b0, 10, 0, 0, 0, "idle4");

    // Async reset mid-hold, button kept pressed through reset release.
    l0 = long_total;
    pb_in = 1'b1;
    waitPulse(30, lat);
    checkRange("mid_press_latency", lat, 1, 18);
    presses++;
    repeat (40) @(negedge clk);
    checkOutput("mid_long_before_rst", long_total - l0, L);
    checkOutput("mid_deb_before_rst", int'(pb_debounced), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_deb", int'(pb_debounced), 0);
    checkOutput("mid_rst_pulse", int'(pb_pulse), 0);
    checkOutput("mid_rst_long", int'(long_pulse), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    waitPulse(30, lat);
    checkRange("mid_rst_fresh_latency", lat, 1, 18);
    presses++;
    applyStimulus(1'b0, 30, 0, 0, 0, "mid_release");
    applyStimulus(1'b1, 30, 1, 0, 1, "final_press");
    presses++;
    applyStimulus(1'b0, 30, 0, 0, 0, "final_release");

    checkOutput("total_pulses", pulse_total, presses);
    checkOutput("count_en_parity", int'(count_en), presses % 2);
    checkOutput("protocol_violations", viol, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
